// File: rtl/tslide4_input_conditioner.sv
// tslide4_input_conditioner: synchronise and debounce the Tslide4 PMOD
// switches/buttons, then emit clean levels and one-cycle edge pulses.
// Optional feature macro: TSLIDE4_TOGGLE_EN adds a per-button toggle latch
// on pb_toggle; without it pb_toggle is tied to 0.

// One conditioning lane: synchroniser chain, stability counter, edge pulses.
module tslide4_debounce_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = 18,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic chg
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // shift the asynchronous pin through the synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    // accept a new level only after it has held for DEBOUNCE_CYCLES cycles;
    // any return to the current level restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            chg   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            chg  <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= ~s;
                chg   <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module tslide4_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = 18,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic [3:0] sw_raw,
    input  logic [3:0] pb_n_raw,
    output logic [3:0] sw_level,
    output logic [3:0] pb_level,
    output logic [3:0] sw_change,
    output logic [3:0] pb_press,
    output logic [3:0] pb_release,
    output logic [3:0] pb_toggle
);
    localparam int NUM_LANES = 8;

    // lanes [3:0] are switches, [7:4] are buttons (inverted to active-high)
    logic [NUM_LANES-1:0] ch_raw, ch_level, ch_rise, ch_fall, ch_chg;
    logic                 lane_unused;

    assign ch_raw = {~pb_n_raw, sw_raw};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tslide4_debounce_lane #(
            .SYNC_STAGES    (SYNC_STAGES),
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk  (clk_25mhz),
            .reset(reset),
            .raw  (ch_raw[i]),
            .level(ch_level[i]),
            .rise (ch_rise[i]),
            .fall (ch_fall[i]),
            .chg  (ch_chg[i])
        );
    end

    assign sw_level   = ch_level[3:0];
    assign pb_level   = ch_level[7:4];
    assign sw_change  = ch_chg[3:0];
    assign pb_press   = ch_rise[7:4];
    assign pb_release = ch_fall[7:4];

    // lane pulses that have no meaning for this lane type are dropped here
    assign lane_unused = &{ch_rise[3:0], ch_fall[3:0], ch_chg[7:4]};

`ifdef TSLIDE4_TOGGLE_EN
    logic [3:0] tog;

    // flip a button's latch in the cycle after its press pulse
    always_ff @(posedge clk_25mhz) begin
        if (reset) tog <= '0;
        else       tog <= tog ^ pb_press;
    end

    assign pb_toggle = tog;
`else
    assign pb_toggle = '0;
`endif
endmodule

// File: tb/tb_tslide4_input_conditioner.sv
// Bench for tslide4_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A sliding-window model predicts every output each cycle; directed
// scenarios pin exact cycle positions with literal expectations.
module tb_tslide4_input_conditioner;
    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int HL   = SYNC + DB;

    logic       clk_25mhz = 1'b0;
    logic       reset     = 1'b1;
    logic [3:0] sw_raw    = 4'h0;
    logic [3:0] pb_n_raw  = 4'hF;
    logic [3:0] sw_level, pb_level, sw_change, pb_press, pb_release, pb_toggle;

    int checks   = 0;
    int failures = 0;

    tslide4_input_conditioner #(
        .SYNC_STAGES(SYNC), .CNT_W(18), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .pb_n_raw  (pb_n_raw),
        .sw_level  (sw_level),
        .pb_level  (pb_level),
        .sw_change (sw_change),
        .pb_press  (pb_press),
        .pb_release(pb_release),
        .pb_toggle (pb_toggle)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, want);
        end
    endtask

    // Model: a channel takes value v when the synchronised input (raw delayed
    // by SYNC edges) has read v, different from the level, for the last DB edges.
    logic [7:0] hist[$];
    logic [7:0] m_lvl  = '0;
    logic [7:0] m_rise = '0;
    logic [7:0] m_fall = '0;
    logic [3:0] m_tog  = '0;
    bit         m_valid = 0;

    always @(posedge clk_25mhz) begin : model
        logic [7:0] w_and, w_or, n_rise, n_fall;
        if (reset) begin
            hist.delete();
            for (int i = 0; i < HL; i++) hist.push_back(8'h00);
            m_lvl = '0; m_rise = '0; m_fall = '0; m_tog = '0;
            m_valid = 1;
        end else if (m_valid) begin
            hist.push_back({~pb_n_raw, sw_raw});
            w_and = '1;
            w_or  = '0;
            for (int k = 0; k < DB; k++) begin
                w_and &= hist[HL - SYNC - k];
                w_or  |= hist[HL - SYNC - k];
            end
`ifdef TSLIDE4_TOGGLE_EN
            m_tog = m_tog ^ m_rise[7:4];
`endif
            n_rise = w_and & ~m_lvl;
            n_fall = ~w_or & m_lvl;
            m_lvl  = (m_lvl | n_rise) & ~n_fall;
            m_rise = n_rise;
            m_fall = n_fall;
            void'(hist.pop_front());
        end
    end

    // compare every output against the model away from the active edge
    always @(negedge clk_25mhz) begin
        if (m_valid) begin
            cmp("m_sw_level",   sw_level,   m_lvl[3:0]);
            cmp("m_pb_level",   pb_level,   m_lvl[7:4]);
            cmp("m_sw_change",  sw_change,  m_rise[3:0] | m_fall[3:0]);
            cmp("m_pb_press",   pb_press,   m_rise[7:4]);
            cmp("m_pb_release", pb_release, m_fall[7:4]);
            cmp("m_pb_toggle",  pb_toggle,  m_tog);
        end
    end

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic idle_reset();
        reset = 1'b1; sw_raw = 4'h0; pb_n_raw = 4'hF;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    function automatic logic [23:0] all_outs();
        return {sw_level, pb_level, sw_change, pb_press, pb_release, pb_toggle};
    endfunction

    logic [3:0]  tog_want;
    logic [11:0] acc;
    int          cnt;
    logic [3:0]  fs, fp;

    initial begin
`ifdef TSLIDE4_TOGGLE_EN
        tog_want = 4'b0010;
`else
        tog_want = 4'b0000;
`endif
        // reset held 3 cycles while inputs toggle
        for (int i = 0; i < 3; i++) begin
            sw_raw = 4'($urandom_range(0, 15)); pb_n_raw = 4'($urandom_range(0, 15));
            tick();
            cmp("rst_outs", all_outs(), 24'h0);
        end
        reset = 1'b0;
        tick();
        cmp("rst_after", all_outs(), 24'h0);

        // clean switch step
        idle_reset();
        sw_raw = 4'b0001;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 5) cmp("sw0_early", sw_level, 4'b0000);
            if (e == 6) begin
                cmp("sw0_level", sw_level, 4'b0001);
                cmp("sw0_change", sw_change, 4'b0001);
                cmp("sw0_pb_quiet", {pb_level, pb_press, pb_release}, 12'h0);
            end
            if (e == 7) cmp("sw0_one_shot", sw_change, 4'b0000);
        end

        // short button glitch must be rejected
        idle_reset();
        acc = '0;
        pb_n_raw = 4'b1011;
        repeat (3) begin tick(); acc |= {pb_level, pb_press, pb_release}; end
        pb_n_raw = 4'hF;
        repeat (10) begin tick(); acc |= {pb_level, pb_press, pb_release}; end
        cmp("pb2_glitch", acc, 12'h0);

        // long press then release on button 1
        idle_reset();
        pb_n_raw = 4'b1101;
        cnt = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            cnt += int'(pb_press[1]);
            if (e == 5) cmp("pb1_early", pb_level, 4'b0000);
            if (e == 6) begin
                cmp("pb1_press", pb_press, 4'b0010);
                cmp("pb1_level", pb_level, 4'b0010);
            end
            if (e == 7) cmp("pb1_toggle", pb_toggle, tog_want);
        end
        cmp("pb1_press_cnt", cnt, 1);
        pb_n_raw = 4'hF;
        cnt = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            cnt += int'(pb_release[1]);
            if (e == 6) begin
                cmp("pb1_release", pb_release, 4'b0010);
                cmp("pb1_level_off", pb_level, 4'b0000);
            end
        end
        cmp("pb1_release_cnt", cnt, 1);
        cmp("pb1_toggle_hold", pb_toggle, tog_want);

        // reset lands mid-debounce of a switch step held through it
        idle_reset();
        sw_raw = 4'b1000;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) begin tick(); cmp("sw3_in_rst", all_outs(), 24'h0); end
        reset = 1'b0;
        acc = '0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 6) acc[3:0] |= sw_change;
            else begin
                cmp("sw3_early_pulse", acc, 12'h0);
                cmp("sw3_change", sw_change, 4'b1000);
                cmp("sw3_level", sw_level, 4'b1000);
            end
        end

        // all eight inputs switch together
        idle_reset();
        sw_raw = 4'hF; pb_n_raw = 4'h0;
        repeat (6) tick();
        cmp("all_sw_change", sw_change, 4'hF);
        cmp("all_pb_press", pb_press, 4'hF);

        // random flips with glitches of varied length and occasional resets
        for (int n = 0; n < 4000; n++) begin
            fs = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            fp = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            if ((n % 500) < 250) begin
                fs &= 4'($urandom_range(0, 15));
                fp &= 4'($urandom_range(0, 15));
            end
            sw_raw   ^= fs;
            pb_n_raw ^= fp;
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
